clap_event_counter: RTL and testbench

Parametrised successor to the board-level clap tally. Consumes single-cycle clap strobes from the clap detector and applies an echo-rejection hold-off. Groups accepted claps into bursts separated by a silence gap, and counts either every accepted clap (raw mode) or only bursts of a programmed length (burst mode). Drives the 7-segment count path in place of the bare accumulator and adds wrap/saturate selection, sticky overflow and a burst-completion strobe.

---
 rtl/clap_pkg.sv | 21 ++
 rtl/cycle_timer.sv | 28 ++
 rtl/clap_event_counter.sv | 104 ++++++++++
 tb/tb_clap_event_counter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/clap_pkg.sv
// Shared encodings for the clap event counter: FSM states, mode select values
// and the sizing helper for the shared hold-off/gap timer.
package clap_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    WAIT = 2'd2
  } clap_state_t;

  localparam logic MODE_RAW   = 1'b0;
  localparam logic MODE_BURST = 1'b1;

  // Wide enough to reach max(hold, gap) - 1; never narrower than one bit.
  function automatic int timer_width(input int hold_cycles, input int gap_cycles);
    int m;
    m = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Restartable up-counter with terminal-count compare against a runtime limit.
// Restart (load to zero) takes priority over counting; tc_o is combinational.
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] last_i,
  output logic         tc_o
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (load_i) begin
      cnt <= '0;
    end else if (en_i) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc_o = (cnt == last_i);

endmodule

// File: rtl/clap_event_counter.sv
// Clap tally with echo hold-off, burst grouping by silence gap, raw/burst counting,
// wrap/saturate overflow and a burst-close strobe. All outputs registered; no backpressure.
module clap_event_counter
  import clap_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int BURST_W     = 3,
  parameter int HOLD_CYCLES = 5_000_000,
  parameter int GAP_CYCLES  = 50_000_000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               pulse_i,
  input  logic               mode_i,
  input  logic               sat_i,
  input  logic [BURST_W-1:0] burst_n_i,
  output logic [CNT_W-1:0]   cnt_o,
  output logic [BURST_W-1:0] burst_len_o,
  output logic               burst_done_o,
  output logic               ovf_o
);

  localparam int TMR_W = timer_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [BURST_W-1:0] LEN_MAX = '1;

  clap_state_t        state;
  logic [BURST_W-1:0] len;
  logic [TMR_W-1:0]   tmr_last;
  logic               tmr_load;
  logic               tmr_tc;
  logic               accept;
  logic               close;
  logic               inc;

  assign accept = pulse_i && !clr_i && (state == IDLE || state == WAIT);
  // A pulse on the expiring WAIT cycle wins over closing the burst.
  assign close  = !clr_i && (state == WAIT) && tmr_tc && !pulse_i;

  assign tmr_last = (state == HOLD) ? TMR_W'(HOLD_CYCLES - 1) : TMR_W'(GAP_CYCLES - 1);
  assign tmr_load = clr_i || accept || tmr_tc || (state == IDLE);

  assign inc = ((mode_i == MODE_RAW) && accept) ||
               ((mode_i == MODE_BURST) && close && (len == burst_n_i) && (burst_n_i != '0));

  cycle_timer #(.W(TMR_W)) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (tmr_load),
    .en_i   (state != IDLE),
    .last_i (tmr_last),
    .tc_o   (tmr_tc)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      len          <= '0;
      burst_len_o  <= '0;
      burst_done_o <= 1'b0;
    end else if (clr_i) begin
      state        <= IDLE;
      len          <= '0;
      burst_len_o  <= '0;
      burst_done_o <= 1'b0;
    end else begin
      burst_done_o <= 1'b0;
      case (state)
        IDLE: if (pulse_i) begin
          len   <= BURST_W'(1);
          state <= HOLD;
        end
        HOLD: if (tmr_tc) state <= WAIT;
        WAIT: if (pulse_i) begin
          if (len != LEN_MAX) len <= len + BURST_W'(1);
          state <= HOLD;
        end else if (tmr_tc) begin
          burst_len_o  <= len;
          burst_done_o <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o <= '0;
      ovf_o <= 1'b0;
    end else if (clr_i) begin
      cnt_o <= '0;
      ovf_o <= 1'b0;
    end else if (inc) begin
      if (&cnt_o) begin
        ovf_o <= 1'b1;
        if (!sat_i) cnt_o <= '0;
      end else begin
        cnt_o <= cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_clap_event_counter.sv
// Directed bench for clap_event_counter with small hold/gap timing.
module tb_clap_event_counter;

  localparam int CNT_W = 4;
  localparam int BURST_W = 3;
  localparam int HOLD_CYCLES = 4;
  localparam int GAP_CYCLES = 10;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic clr_i = 1'b0;
  logic pulse_i = 1'b0;
  logic mode_i = 1'b0;
  logic sat_i = 1'b0;
  logic [BURST_W-1:0] burst_n_i = '0;
  logic [CNT_W-1:0] cnt_o;
  logic [BURST_W-1:0] burst_len_o;
  logic burst_done_o;
  logic ovf_o;

  int checks = 0;
  int failures = 0;
  int pulse_at[$];
  int done_cyc[$];
  int done_len[$];

  clap_event_counter #(
    .CNT_W(CNT_W), .BURST_W(BURST_W), .HOLD_CYCLES(HOLD_CYCLES), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .pulse_i(pulse_i), .mode_i(mode_i),
    .sat_i(sat_i), .burst_n_i(burst_n_i), .cnt_o(cnt_o), .burst_len_o(burst_len_o),
    .burst_done_o(burst_done_o), .ovf_o(ovf_o)
  );

  always #5 clk_i = ~clk_i;

  // Called at a negedge; cycle c is sampled by the posedge ending it, and outputs
  // seen at the following negedge belong to cycle c+1.
  task automatic run_sched(input int ncyc);
    done_cyc.delete();
    done_len.delete();
    for (int c = 0; c < ncyc; c++) begin
      pulse_i = 1'b0;
      foreach (pulse_at[k]) if (pulse_at[k] == c) pulse_i = 1'b1;
      @(negedge clk_i);
      if (burst_done_o === 1'b1) begin
        done_cyc.push_back(c + 1);
        done_len.push_back(int'(burst_len_o));
      end
    end
    pulse_i = 1'b0;
  endtask

  task automatic do_clr();
    clr_i = 1'b1;
    @(negedge clk_i);
    clr_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    checks++; if (cnt_o !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt_o); end
    checks++; if (burst_len_o !== 3'd0) begin failures++; $display("FAIL reset_len got=%0d exp=0", burst_len_o); end
    checks++; if (burst_done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", burst_done_o); end
    checks++; if (ovf_o !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", ovf_o); end
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_raw_spaced();
    int exp_cyc[3];
    exp_cyc = '{15, 35, 55};
    do_clr();
    mode_i = 1'b0;
    pulse_at = '{0, 20, 40};
    run_sched(60);
    checks++; if (cnt_o !== 4'd3) begin failures++; $display("FAIL raw_cnt got=%0d exp=3", cnt_o); end
    checks++; if (done_cyc.size() != 3) begin failures++; $display("FAIL raw_done_count got=%0d exp=3", done_cyc.size()); end
    for (int i = 0; i < 3 && i < done_cyc.size(); i++) begin
      checks++; if (done_cyc[i] != exp_cyc[i]) begin failures++; $display("FAIL raw_done_cycle[%0d] got=%0d exp=%0d", i, done_cyc[i], exp_cyc[i]); end
      checks++; if (done_len[i] != 1) begin failures++; $display("FAIL raw_done_len[%0d] got=%0d exp=1", i, done_len[i]); end
    end
  endtask

  task automatic test_hold_ignore();
    do_clr();
    mode_i = 1'b0;
    pulse_at = '{0, 2};
    run_sched(20);
    checks++; if (cnt_o !== 4'd1) begin failures++; $display("FAIL hold_cnt got=%0d exp=1", cnt_o); end
    checks++; if (burst_len_o !== 3'd1) begin failures++; $display("FAIL hold_len got=%0d exp=1", burst_len_o); end
    checks++; if (done_cyc.size() != 1 || done_cyc[0] != 15) begin failures++; $display("FAIL hold_done got_n=%0d exp cycle 15", done_cyc.size()); end
  endtask

  task automatic test_burst_mode();
    do_clr();
    mode_i = 1'b1;
    burst_n_i = 3'd2;
    pulse_at = '{0, 8};
    run_sched(30);
    checks++; if (done_cyc.size() != 1 || done_cyc[0] != 23) begin failures++; $display("FAIL burst2_done got_n=%0d exp cycle 23", done_cyc.size()); end
    checks++; if (burst_len_o !== 3'd2) begin failures++; $display("FAIL burst2_len got=%0d exp=2", burst_len_o); end
    checks++; if (cnt_o !== 4'd1) begin failures++; $display("FAIL burst2_cnt got=%0d exp=1", cnt_o); end
    pulse_at = '{0, 5, 10};
    run_sched(30);
    checks++; if (done_cyc.size() != 1 || done_cyc[0] != 25) begin failures++; $display("FAIL burst3_done got_n=%0d exp cycle 25", done_cyc.size()); end
    checks++; if (burst_len_o !== 3'd3) begin failures++; $display("FAIL burst3_len got=%0d exp=3", burst_len_o); end
    checks++; if (cnt_o !== 4'd1) begin failures++; $display("FAIL burst3_cnt got=%0d exp=1", cnt_o); end
  endtask

  // Pulse lands on the last WAIT cycle: it extends the burst instead of closing it.
  task automatic test_gap_edge();
    burst_n_i = 3'd2;
    pulse_at = '{0, 14};
    run_sched(35);
    checks++; if (done_cyc.size() != 1 || done_cyc[0] != 29) begin failures++; $display("FAIL gap_edge_done got_n=%0d exp cycle 29", done_cyc.size()); end
    checks++; if (burst_len_o !== 3'd2) begin failures++; $display("FAIL gap_edge_len got=%0d exp=2", burst_len_o); end
    checks++; if (cnt_o !== 4'd2) begin failures++; $display("FAIL gap_edge_cnt got=%0d exp=2", cnt_o); end
  endtask

  task automatic test_len_sat();
    burst_n_i = 3'd7;
    pulse_at = '{0, 5, 10, 15, 20, 25, 30, 35};
    run_sched(55);
    checks++; if (done_cyc.size() != 1 || done_cyc[0] != 50) begin failures++; $display("FAIL len_sat_done got_n=%0d exp cycle 50", done_cyc.size()); end
    checks++; if (burst_len_o !== 3'd7) begin failures++; $display("FAIL len_sat_len got=%0d exp=7", burst_len_o); end
    checks++; if (cnt_o !== 4'd3) begin failures++; $display("FAIL len_sat_cnt got=%0d exp=3", cnt_o); end
  endtask

  task automatic test_overflow();
    pulse_at.delete();
    for (int i = 0; i < 17; i++) pulse_at.push_back(i * 5);
    do_clr();
    mode_i = 1'b0;
    sat_i = 1'b0;
    run_sched(82);
    checks++; if (cnt_o !== 4'd1) begin failures++; $display("FAIL wrap_cnt got=%0d exp=1", cnt_o); end
    checks++; if (ovf_o !== 1'b1) begin failures++; $display("FAIL wrap_ovf got=%0b exp=1", ovf_o); end
    do_clr();
    checks++; if (ovf_o !== 1'b0) begin failures++; $display("FAIL clr_ovf got=%0b exp=0", ovf_o); end
    sat_i = 1'b1;
    run_sched(82);
    checks++; if (cnt_o !== 4'd15) begin failures++; $display("FAIL sat_cnt got=%0d exp=15", cnt_o); end
    checks++; if (ovf_o !== 1'b1) begin failures++; $display("FAIL sat_ovf got=%0b exp=1", ovf_o); end
    sat_i = 1'b0;
  endtask

  task automatic test_reset_midburst();
    do_clr();
    mode_i = 1'b0;
    pulse_at = '{0};
    run_sched(6);
    checks++; if (cnt_o !== 4'd1) begin failures++; $display("FAIL pre_rst_cnt got=%0d exp=1", cnt_o); end
    #2 rst_i = 1'b1;
    #1;
    checks++; if (cnt_o !== 4'd0) begin failures++; $display("FAIL async_rst_cnt got=%0d exp=0", cnt_o); end
    checks++; if (burst_len_o !== 3'd0 || burst_done_o !== 1'b0 || ovf_o !== 1'b0) begin
      failures++; $display("FAIL async_rst_outs len=%0d done=%0b ovf=%0b exp all 0", burst_len_o, burst_done_o, ovf_o);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    pulse_at.delete();
    run_sched(30);
    checks++; if (done_cyc.size() != 0) begin failures++; $display("FAIL rst_no_done got=%0d exp=0", done_cyc.size()); end
  endtask

  task automatic test_clr_pulse();
    do_clr();
    mode_i = 1'b0;
    pulse_at = '{0, 5, 10, 15, 20};
    run_sched(22);
    checks++; if (cnt_o !== 4'd5) begin failures++; $display("FAIL pre_clr_cnt got=%0d exp=5", cnt_o); end
    clr_i = 1'b1;
    pulse_i = 1'b1;
    @(negedge clk_i);
    clr_i = 1'b0;
    pulse_i = 1'b0;
    checks++; if (cnt_o !== 4'd0) begin failures++; $display("FAIL clr_cnt got=%0d exp=0", cnt_o); end
    checks++; if (ovf_o !== 1'b0 || burst_len_o !== 3'd0) begin failures++; $display("FAIL clr_outs ovf=%0b len=%0d exp 0", ovf_o, burst_len_o); end
    pulse_at = '{0};
    run_sched(20);
    checks++; if (done_cyc.size() != 1 || done_cyc[0] != 15) begin failures++; $display("FAIL clr_idle_done got_n=%0d exp one at cycle 15", done_cyc.size()); end
    checks++; if (cnt_o !== 4'd1) begin failures++; $display("FAIL clr_after_cnt got=%0d exp=1", cnt_o); end
  endtask

  initial begin
    test_reset();
    test_raw_spaced();
    test_hold_ignore();
    test_burst_mode();
    test_gap_edge();
    test_len_sat();
    test_overflow();
    test_reset_midburst();
    test_clr_pulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
